// File: rtl/div_unit_if.sv
// Divider request/result bundle between the execute stage (master) and div_unit (slave).
// The request holds while the divider stalls the pipeline; results come back as a one-cycle valid pulse.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_div;
  logic             cancel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             div_stall;
  logic             result_valid;
  logic [WIDTH-1:0] result_hi;
  logic [WIDTH-1:0] result_lo;

  modport master (
    output start, signed_div, cancel, a, b,
    input  div_stall, result_valid, result_hi, result_lo
  );

  modport slave (
    input  start, signed_div, cancel, a, b,
    output div_stall, result_valid, result_hi, result_lo
  );
endinterface

// File: rtl/div_unit.sv
// Bit-serial restoring divider (DIV/DIVU): quotient to LO, remainder to HI; WIDTH+1 stall cycles, or 1 on divide-by-zero.
// No backpressure on results: result_valid pulses for one cycle, and div_stall freezes the pipeline while busy.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  div_unit_if.slave bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, stateNext;
  logic [WIDTH-1:0] remReg, remNext;
  logic [WIDTH-1:0] quotReg, quotNext;
  logic [WIDTH-1:0] divisorReg, divisorNext;
  logic [WIDTH-1:0] hiReg, hiNext;
  logic [WIDTH-1:0] loReg, loNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic             negQuot, negQuotNext;
  logic             negRem, negRemNext;

  logic             accept;
  logic             lastIter;
  logic [WIDTH-1:0] absA, absB;
  logic [WIDTH:0]   remWide, trial;
  logic [WIDTH-1:0] stepRem, stepQuot;

  assign accept   = (state == IDLE) && bus.start && !bus.cancel;
  assign lastIter = (cnt == CNT_W'(WIDTH - 1));

  // Magnitudes wrap mod 2^WIDTH, so the most negative value stays as its unsigned bit pattern.
  always_comb begin
    absA = (bus.signed_div && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    absB = (bus.signed_div && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  end

  // One restoring step; the shifted remainder needs WIDTH+1 bits since the divisor may use all WIDTH bits.
  always_comb begin
    remWide = {remReg, quotReg[WIDTH-1]};
    trial   = remWide - {1'b0, divisorReg};
    if (!trial[WIDTH]) begin
      stepRem  = trial[WIDTH-1:0];
      stepQuot = {quotReg[WIDTH-2:0], 1'b1};
    end else begin
      stepRem  = remWide[WIDTH-1:0];
      stepQuot = {quotReg[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext   = state;
    remNext     = remReg;
    quotNext    = quotReg;
    divisorNext = divisorReg;
    hiNext      = hiReg;
    loNext      = loReg;
    cntNext     = cnt;
    negQuotNext = negQuot;
    negRemNext  = negRem;

    unique case (state)
      IDLE: begin
        if (accept) begin
          negQuotNext = bus.signed_div && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          negRemNext  = bus.signed_div && bus.a[WIDTH-1];
          divisorNext = absB;
          if (bus.b == '0) begin
            stateNext = DONE;
            loNext    = '1;
            hiNext    = bus.a;
          end else begin
            stateNext = BUSY;
            cntNext   = '0;
            remNext   = '0;
            quotNext  = absA;
          end
        end
      end
      BUSY: begin
        if (bus.cancel) begin
          stateNext = IDLE;
        end else begin
          remNext  = stepRem;
          quotNext = stepQuot;
          cntNext  = cnt + CNT_W'(1);
          if (lastIter) begin
            stateNext = DONE;
            loNext    = negQuot ? -stepQuot : stepQuot;
            hiNext    = negRem  ? -stepRem  : stepRem;
          end
        end
      end
      DONE: begin
        // The instruction that started this op may still hold start high here; it must not restart.
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      remReg     <= '0;
      quotReg    <= '0;
      divisorReg <= '0;
      hiReg      <= '0;
      loReg      <= '0;
      cnt        <= '0;
      negQuot    <= 1'b0;
      negRem     <= 1'b0;
    end else begin
      remReg     <= remNext;
      quotReg    <= quotNext;
      divisorReg <= divisorNext;
      hiReg      <= hiNext;
      loReg      <= loNext;
      cnt        <= cntNext;
      negQuot    <= negQuotNext;
      negRem     <= negRemNext;
    end
  end

  assign bus.div_stall    = accept || ((state == BUSY) && !bus.cancel);
  assign bus.result_valid = (state == DONE);
  assign bus.result_hi    = hiReg;
  assign bus.result_lo    = loReg;
endmodule

// File: tb/tb_div_unit.sv
// Directed checks of div_unit: reset, DIV/DIVU results and stall length, divide-by-zero,
// back-to-back starts, cancel and mid-operation reset.
module tb_div_unit;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds start until result_valid, counting stall cycles; drops start in the DONE cycle.
  task automatic runDiv(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                        input int expStalls, input logic [31:0] expLo, input logic [31:0] expHi);
    int stalls = 0;
    bit seen = 0;
    bus.start      = 1'b1;
    bus.signed_div = s;
    bus.a          = a;
    bus.b          = b;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (bus.result_valid) begin
        seen = 1;
        break;
      end
      if (bus.div_stall) stalls++;
      tick();
    end
    checkVal({tag, "_valid"}, 32'(seen), 32'd1);
    checkVal({tag, "_stalls"}, 32'(stalls), 32'(expStalls));
    checkVal({tag, "_donestall"}, 32'(bus.div_stall), 32'd0);
    checkVal({tag, "_lo"}, bus.result_lo, expLo);
    checkVal({tag, "_hi"}, bus.result_hi, expHi);
    bus.start = 1'b0;
    tick();
  endtask

  initial begin
    int pulses;
    int validSeen;
    logic [31:0] secondLo, secondHi;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.signed_div = 1'b0;
    bus.cancel = 1'b0;
    bus.a = '0;
    bus.b = '0;
    tick();
    tick();
    checkVal("rst_stall", 32'(bus.div_stall), 32'd0);
    checkVal("rst_valid", 32'(bus.result_valid), 32'd0);
    checkVal("rst_hi", bus.result_hi, 32'd0);
    checkVal("rst_lo", bus.result_lo, 32'd0);
    rst = 1'b0;
    tick();

    runDiv("divu_100_7", 1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2);
    runDiv("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    runDiv("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 32'd1);
    runDiv("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0);
    runDiv("divu_min_max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000);
    runDiv("divu_by0", 1'b0, 32'h0000_1234, 32'd0, 1, 32'hFFFF_FFFF, 32'h0000_1234);
    runDiv("div_by0", 1'b1, 32'hFFFF_FFF0, 32'd0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFF0);

    // Start held through DONE, then a second op issued by the next instruction.
    pulses = 0;
    secondLo = '0;
    secondHi = '0;
    bus.start = 1'b1;
    bus.signed_div = 1'b0;
    bus.a = 32'd20;
    bus.b = 32'd4;
    for (int i = 0; i < 90; i++) begin
      #1;
      if (bus.result_valid) begin
        pulses++;
        if (pulses == 1) begin
          checkVal("b2b_first_lo", bus.result_lo, 32'd5);
          bus.a = 32'd9;
          bus.b = 32'd3;
        end else begin
          secondLo = bus.result_lo;
          secondHi = bus.result_hi;
          bus.start = 1'b0;
        end
      end
      tick();
    end
    bus.start = 1'b0;
    checkVal("b2b_pulses", 32'(pulses), 32'd2);
    checkVal("b2b_second_lo", secondLo, 32'd3);
    checkVal("b2b_second_hi", secondHi, 32'd0);

    // Cancel together with start in IDLE: no stall, no op.
    runDiv("divu_50_5", 1'b0, 32'd50, 32'd5, 33, 32'd10, 32'd0);
    bus.start = 1'b1;
    bus.cancel = 1'b1;
    bus.a = 32'd77;
    bus.b = 32'd7;
    #1;
    checkVal("cancel_idle_stall", 32'(bus.div_stall), 32'd0);
    tick();
    bus.start = 1'b0;
    bus.cancel = 1'b0;
    #1;
    checkVal("cancel_idle_valid", 32'(bus.result_valid), 32'd0);
    checkVal("cancel_idle_stall2", 32'(bus.div_stall), 32'd0);
    tick();

    // Cancel at cnt=5: no result, previous outputs retained.
    bus.start = 1'b1;
    bus.signed_div = 1'b0;
    bus.a = 32'd100;
    bus.b = 32'd7;
    tick();
    for (int i = 0; i < 5; i++) tick();
    bus.cancel = 1'b1;
    #1;
    checkVal("cancel_busy_stall", 32'(bus.div_stall), 32'd0);
    tick();
    bus.start = 1'b0;
    bus.cancel = 1'b0;
    validSeen = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (bus.result_valid) validSeen++;
      tick();
    end
    checkVal("cancel_busy_nopulse", 32'(validSeen), 32'd0);
    checkVal("cancel_busy_lo", bus.result_lo, 32'd10);
    checkVal("cancel_busy_hi", bus.result_hi, 32'd0);

    // Reset at cnt=10 after a result with a nonzero remainder.
    runDiv("divu_100_7b", 1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2);
    bus.start = 1'b1;
    bus.a = 32'd1000;
    bus.b = 32'd3;
    tick();
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    bus.start = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    checkVal("rst_busy_stall", 32'(bus.div_stall), 32'd0);
    checkVal("rst_busy_valid", 32'(bus.result_valid), 32'd0);
    checkVal("rst_busy_hi", bus.result_hi, 32'd0);
    checkVal("rst_busy_lo", bus.result_lo, 32'd0);
    tick();

    runDiv("divu_after_rst", 1'b0, 32'd9, 32'd3, 33, 32'd3, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
